// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller.
// Sequences one full-adder cell (two half-adder stages plus an OR for the
// carry) across WIDTH-bit operands, LSB first, one bit per clock. A
// start/busy/done handshake fronts the datapath. The sum and carry outputs
// hold their last result until the next completion or reset.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             c_reg;
  logic [CW-1:0]    cnt;

  logic accept;
  logic last;

  // Full-adder cell built from two half-adder stages.
  logic ha1_s, ha1_c;
  logic ha2_s, ha2_c;
  logic s_bit, c_next;

  assign ha1_s  = a_sr[0] ^ b_sr[0];
  assign ha1_c  = a_sr[0] & b_sr[0];
  assign ha2_s  = ha1_s ^ c_reg;
  assign ha2_c  = ha1_s & c_reg;
  assign s_bit  = ha2_s;
  assign c_next = ha1_c | ha2_c;

  // start is honoured only outside RUN, so operands offered mid-operation
  // never disturb the shift registers.
  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(WIDTH - 1));

  // Status outputs decode straight from the state register, so they are
  // glitch-free and have no path from any input.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, bit-serial add, and result publication on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      c_reg  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      carry  <= 1'b0;
    end else if (accept) begin
      a_sr   <= in_a;
      b_sr   <= in_b;
      res_sr <= '0;
      c_reg  <= 1'b0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {s_bit, res_sr[WIDTH-1:1]};
      c_reg  <= c_next;
      if (last) begin
        // The final bit goes straight into sum; the counter stays put so it
        // never wraps within an operation.
        sum   <= {s_bit, res_sr[WIDTH-1:1]};
        carry <= c_next;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized checks for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;
  localparam int BOUND = 40;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  int n_pass  = 0;
  int n_total = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in_a  (in_a),
    .in_b  (in_b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done, counting edges and busy cycles; also counts cycles where
  // sum differs from hold_val before done shows up.
  task automatic wait_done(input logic [WIDTH-1:0] hold_val,
                           output int lat, output int busy_cyc, output int hold_bad);
    lat      = 0;
    busy_cyc = busy ? 1 : 0;
    hold_bad = 0;
    while (!done && lat < BOUND) begin
      if (sum !== hold_val) hold_bad++;
      tick();
      lat++;
      if (busy) busy_cyc++;
    end
  endtask

  // Counts done pulses over n cycles.
  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) pulses++;
    end
  endtask

  // One complete operation from an idle controller, fully checked.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] exp_sum, input logic exp_carry);
    int lat, bc, hb;
    start = 1'b1;
    in_a  = a;
    in_b  = b;
    tick();
    start = 1'b0;
    in_a  = WIDTH'($urandom);
    in_b  = WIDTH'($urandom);
    wait_done(sum, lat, bc, hb);
    check({tag, " latency"}, lat, 8);
    check({tag, " sum"}, sum, exp_sum);
    check({tag, " carry"}, carry, exp_carry);
    check({tag, " busy cycles"}, bc, 8);
    check({tag, " busy at done"}, busy, 0);
    tick();
    check({tag, " done drop"}, done, 0);
  endtask

  initial begin
    int lat, bc, hb, pulses;
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH:0]   ref_val;

    rst_n = 1'b0;
    start = 1'b0;
    in_a  = '0;
    in_b  = '0;
    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", sum, 0);
    check("reset carry", carry, 0);
    rst_n = 1'b1;
    tick();

    // Directed vectors.
    do_op("0F+01", 8'h0F, 8'h01, 8'h10, 1'b0);
    do_op("FF+01", 8'hFF, 8'h01, 8'h00, 1'b1);
    do_op("FF+FF", 8'hFF, 8'hFF, 8'hFE, 1'b1);
    do_op("00+00", 8'h00, 8'h00, 8'h00, 1'b0);
    do_op("A5+5A", 8'hA5, 8'h5A, 8'hFF, 1'b0);

    // Back-to-back with start held high.
    start = 1'b1;
    in_a  = 8'h03;
    in_b  = 8'h04;
    tick();
    in_a  = 8'h80;
    in_b  = 8'h80;
    wait_done(sum, lat, bc, hb);
    check("b2b first latency", lat, 8);
    check("b2b first sum", sum, 8'h07);
    check("b2b first carry", carry, 0);
    tick();
    start = 1'b0;
    check("b2b rerun busy", busy, 1);
    wait_done(8'h07, lat, bc, hb);
    check("b2b spacing", lat + 1, 9);
    check("b2b sum hold", hb, 0);
    check("b2b second sum", sum, 8'h00);
    check("b2b second carry", carry, 1);
    tick();

    // start during RUN is ignored.
    start = 1'b1;
    in_a  = 8'h10;
    in_b  = 8'h20;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    in_a  = 8'hFF;
    in_b  = 8'hFF;
    tick();
    start = 1'b0;
    wait_done(sum, lat, bc, hb);
    check("ignore latency", lat + 3, 8);
    check("ignore sum", sum, 8'h30);
    check("ignore carry", carry, 0);
    count_done(12, pulses);
    check("ignore extra done", pulses, 0);

    // Reset mid-RUN.
    start = 1'b1;
    in_a  = 8'hFF;
    in_b  = 8'h01;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst sum", sum, 0);
    check("midrst carry", carry, 0);
    tick();
    tick();
    check("midrst held sum", sum, 0);
    rst_n = 1'b1;
    count_done(12, pulses);
    check("midrst no done", pulses, 0);
    do_op("01+01", 8'h01, 8'h01, 8'h02, 1'b0);

    // Randomized operands against a plain a+b reference.
    for (int i = 0; i < 1000; i++) begin
      ra      = WIDTH'($urandom);
      rb      = WIDTH'($urandom);
      ref_val = {1'b0, ra} + {1'b0, rb};
      do_op("rand", ra, rb, ref_val[WIDTH-1:0], ref_val[WIDTH]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
